// File: rtl/mips_alu_sequencer.sv
// Multicycle issue/commit controller wrapped around an external MIPS ALU.
// Build with MIPS_ALU_OVF_TRAP_EN defined to enable the signed-overflow trap.
module mips_alu_sequencer #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [OP_W-1:0]   ALUOp,
  output logic [DATA_W-1:0] content1,
  output logic [DATA_W-1:0] content2,
  input  logic [DATA_W-1:0] result,
  input  logic              signal_zero,
  output logic              done,
  output logic              wb_en,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              branch_taken,
  output logic [DATA_W-1:0] branch_offset,
  output logic              jump_en,
  output logic [DATA_W-1:0] jump_target,
  output logic              illegal,
  output logic              ovf_trap
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_COMMIT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [5:0]        r_op;
  logic [4:0]        r_rt_f;
  logic [15:0]       r_imm;
  logic [DATA_W-1:0] r_rs;
  logic [DATA_W-1:0] r_rt;

  logic [OP_W-1:0]   r_aluop;
  logic [DATA_W-1:0] r_c1;
  logic [DATA_W-1:0] r_c2;
  logic [4:0]        r_wb_addr;
  logic [DATA_W-1:0] r_boff;
  logic [DATA_W-1:0] r_jt;
  logic              r_is_br;
  logic              r_is_jr;
  logic              r_is_ill;
  logic              r_is_add;
  logic              r_is_sub;

  logic [DATA_W-1:0] r_wb_data;
  logic              r_br_taken;
  logic              r_done;
  logic              r_wb_en;
  logic              r_jump_en;
  logic              r_illegal;
  logic              r_ovf;

  logic [5:0]        w_funct;
  logic [4:0]        w_rd;
  logic [4:0]        w_shamt;
  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_zext;
  logic [DATA_W-1:0] w_shext;
  logic [DATA_W-1:0] w_boff;

  logic [OP_W-1:0]   w_aluop;
  logic [DATA_W-1:0] w_c1;
  logic [DATA_W-1:0] w_c2;
  logic [4:0]        w_dst;
  logic              w_br;
  logic              w_jr;
  logic              w_ill;
  logic              w_add;
  logic              w_sub;

  logic              w_ovf_raw;
  logic              w_ovf_en;
  logic              w_ovf;
  logic              w_wb_ok;

  assign w_funct = r_imm[5:0];
  assign w_rd    = r_imm[15:11];
  assign w_shamt = r_imm[10:6];
  assign w_sext  = {{(DATA_W-16){r_imm[15]}}, r_imm};
  assign w_zext  = {{(DATA_W-16){1'b0}}, r_imm};
  assign w_shext = {{(DATA_W-5){1'b0}}, w_shamt};
  assign w_boff  = {w_sext[DATA_W-3:0], 2'b00};

  always_comb begin
    w_aluop = '0;
    w_c1    = '0;
    w_c2    = '0;
    w_dst   = '0;
    w_br    = 1'b0;
    w_jr    = 1'b0;
    w_ill   = 1'b0;
    w_add   = 1'b0;
    w_sub   = 1'b0;
    case (r_op)
      6'h00: begin
        w_c1  = r_rs;
        w_c2  = r_rt;
        w_dst = w_rd;
        case (w_funct)
          6'h20: begin
            w_aluop = OP_W'(1);
            w_add   = 1'b1;
          end
          6'h21: w_aluop = OP_W'(11);
          6'h22: begin
            w_aluop = OP_W'(9);
            w_sub   = 1'b1;
          end
          6'h23: w_aluop = OP_W'(8);
          6'h24: w_aluop = OP_W'(2);
          6'h25: w_aluop = OP_W'(4);
          6'h27: w_aluop = OP_W'(3);
          6'h2A: w_aluop = OP_W'(5);
          6'h2B: w_aluop = OP_W'(10);
          6'h00: begin
            w_aluop = OP_W'(6);
            w_c1    = r_rt;
            w_c2    = w_shext;
          end
          6'h02: begin
            w_aluop = OP_W'(7);
            w_c1    = r_rt;
            w_c2    = w_shext;
          end
          6'h08: w_jr = 1'b1;
          default: begin
            w_ill = 1'b1;
            w_c1  = '0;
            w_c2  = '0;
            w_dst = '0;
          end
        endcase
      end
      6'h04, 6'h05: begin
        w_aluop = (r_op == 6'h04) ? OP_W'(12) : OP_W'(13);
        w_c1    = r_rs;
        w_c2    = r_rt;
        w_br    = 1'b1;
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D: begin
        w_c1  = r_rs;
        w_c2  = w_sext;
        w_dst = r_rt_f;
        case (r_op)
          6'h08: begin
            w_aluop = OP_W'(1);
            w_add   = 1'b1;
          end
          6'h09: w_aluop = OP_W'(11);
          6'h0A: w_aluop = OP_W'(5);
          6'h0B: w_aluop = OP_W'(10);
          6'h0C: begin
            w_aluop = OP_W'(2);
            w_c2    = w_zext;
          end
          default: begin
            w_aluop = OP_W'(4);
            w_c2    = w_zext;
          end
        endcase
      end
      default: w_ill = 1'b1;
    endcase
  end

  // Signed overflow seen against the operands actually presented to the ALU
  assign w_ovf_raw =
    (r_is_add & (r_c1[DATA_W-1] == r_c2[DATA_W-1])
              & (result[DATA_W-1] != r_c1[DATA_W-1])) |
    (r_is_sub & (r_c1[DATA_W-1] != r_c2[DATA_W-1])
              & (result[DATA_W-1] != r_c1[DATA_W-1]));

`ifdef MIPS_ALU_OVF_TRAP_EN
  assign w_ovf_en = 1'b1;
`else
  assign w_ovf_en = 1'b0;
`endif

  assign w_ovf   = w_ovf_raw & w_ovf_en;
  assign w_wb_ok = ~r_is_ill & ~r_is_br & ~r_is_jr
                 & (r_wb_addr != 5'd0) & ~w_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (instr_valid) w_next = S_DECODE;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op       <= '0;
      r_rt_f     <= '0;
      r_imm      <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_aluop    <= '0;
      r_c1       <= '0;
      r_c2       <= '0;
      r_wb_addr  <= '0;
      r_boff     <= '0;
      r_jt       <= '0;
      r_is_br    <= 1'b0;
      r_is_jr    <= 1'b0;
      r_is_ill   <= 1'b0;
      r_is_add   <= 1'b0;
      r_is_sub   <= 1'b0;
      r_wb_data  <= '0;
      r_br_taken <= 1'b0;
      r_done     <= 1'b0;
      r_wb_en    <= 1'b0;
      r_jump_en  <= 1'b0;
      r_illegal  <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_op   <= instr[31:26];
            r_rt_f <= instr[20:16];
            r_imm  <= instr[15:0];
            r_rs   <= rs_data;
            r_rt   <= rt_data;
          end
        end
        S_DECODE: begin
          r_aluop   <= w_aluop;
          r_c1      <= w_c1;
          r_c2      <= w_c2;
          r_wb_addr <= w_dst;
          r_boff    <= w_boff;
          r_jt      <= w_jr ? r_rs : '0;
          r_is_br   <= w_br;
          r_is_jr   <= w_jr;
          r_is_ill  <= w_ill;
          r_is_add  <= w_add;
          r_is_sub  <= w_sub;
        end
        S_EXEC: begin
          r_wb_data  <= result;
          r_br_taken <= r_is_br & signal_zero;
          r_done     <= 1'b1;
          r_wb_en    <= w_wb_ok;
          r_jump_en  <= r_is_jr;
          r_illegal  <= r_is_ill;
          r_ovf      <= w_ovf;
        end
        S_COMMIT: begin
          r_br_taken <= 1'b0;
          r_done     <= 1'b0;
          r_wb_en    <= 1'b0;
          r_jump_en  <= 1'b0;
          r_illegal  <= 1'b0;
          r_ovf      <= 1'b0;
          r_aluop    <= '0;
          r_c1       <= '0;
          r_c2       <= '0;
        end
        default: ;
      endcase
    end
  end

  assign instr_ready   = (r_state == S_IDLE);
  assign ALUOp         = r_aluop;
  assign content1      = r_c1;
  assign content2      = r_c2;
  assign done          = r_done;
  assign wb_en         = r_wb_en;
  assign wb_addr       = r_wb_addr;
  assign wb_data       = r_wb_data;
  assign branch_taken  = r_br_taken;
  assign branch_offset = r_boff;
  assign jump_en       = r_jump_en;
  assign jump_target   = r_jt;
  assign illegal       = r_illegal;
  assign ovf_trap      = r_ovf;

endmodule

// File: tb/tb_mips_alu_sequencer.sv
// Directed bench for mips_alu_sequencer with a behavioural ALU model.
module tb_mips_alu_sequencer;

`ifdef MIPS_ALU_OVF_TRAP_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr, rs_data, rt_data;
  logic [3:0]  ALUOp;
  logic [31:0] content1, content2, result;
  logic        signal_zero;
  logic        done, wb_en, branch_taken, jump_en, illegal, ovf_trap;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, branch_offset, jump_target;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mips_alu_sequencer #(.DATA_W(32), .OP_W(4)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .ALUOp(ALUOp), .content1(content1), .content2(content2),
    .result(result), .signal_zero(signal_zero),
    .done(done), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_en(jump_en), .jump_target(jump_target),
    .illegal(illegal), .ovf_trap(ovf_trap)
  );

  // Behavioural ALU
  always_comb begin
    result      = 32'h0;
    signal_zero = 1'b0;
    case (ALUOp)
      4'd1, 4'd11: result = content1 + content2;
      4'd9, 4'd8:  result = content1 - content2;
      4'd2:  result = content1 & content2;
      4'd4:  result = content1 | content2;
      4'd3:  result = ~(content1 | content2);
      4'd5:  result = {31'b0, $signed(content1) < $signed(content2)};
      4'd10: result = {31'b0, content1 < content2};
      4'd6:  result = content1 << content2[4:0];
      4'd7:  result = content1 >> content2[4:0];
      default: result = 32'h0;
    endcase
    case (ALUOp)
      4'd12:   signal_zero = (content1 == content2);
      4'd13:   signal_zero = (content1 != content2);
      default: signal_zero = (result == 32'h0);
    endcase
  end

  typedef struct {
    logic [31:0] instr, rs, rt;
    logic [3:0]  op;
    logic [31:0] c1, c2;
    logic        wb_en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        chk_wb;
    logic        br;
    logic [31:0] boff;
    logic        chk_boff;
    logic        jmp;
    logic [31:0] jt;
    logic        ill;
    logic        ovf;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int k);
    string p;
    p = $sformatf("v%0d", k);
    @(negedge clk);
    chk({p, ".ready"}, 32'(instr_ready), 32'd1);
    instr       = v.instr;
    rs_data     = v.rs;
    rt_data     = v.rt;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    rs_data     = 32'hDEADBEEF;
    rt_data     = 32'hDEADBEEF;
    chk({p, ".dec_ready"}, 32'(instr_ready), 32'd0);
    @(posedge clk); #1;
    chk({p, ".aluop"}, 32'(ALUOp), 32'(v.op));
    chk({p, ".c1"}, content1, v.c1);
    chk({p, ".c2"}, content2, v.c2);
    chk({p, ".exec_done"}, 32'(done), 32'd0);
    @(posedge clk); #1;
    chk({p, ".done"}, 32'(done), 32'd1);
    chk({p, ".wb_en"}, 32'(wb_en), 32'(v.wb_en));
    if (v.chk_wb) begin
      chk({p, ".wb_addr"}, 32'(wb_addr), 32'(v.addr));
      chk({p, ".wb_data"}, wb_data, v.data);
    end
    chk({p, ".br"}, 32'(branch_taken), 32'(v.br));
    if (v.chk_boff) chk({p, ".boff"}, branch_offset, v.boff);
    chk({p, ".jump_en"}, 32'(jump_en), 32'(v.jmp));
    if (v.jmp) chk({p, ".jt"}, jump_target, v.jt);
    chk({p, ".illegal"}, 32'(illegal), 32'(v.ill));
    chk({p, ".ovf"}, 32'(ovf_trap), 32'(v.ovf));
    @(posedge clk); #1;
    chk({p, ".post_done"}, 32'(done), 32'd0);
    chk({p, ".post_wb_en"}, 32'(wb_en), 32'd0);
    chk({p, ".post_ready"}, 32'(instr_ready), 32'd1);
    chk({p, ".post_aluop"}, 32'(ALUOp), 32'd0);
    if (v.chk_wb) chk({p, ".hold_data"}, wb_data, v.data);
  endtask

  initial begin
    int seen;
    vecs[0]  = '{32'h00221820, 32'd5, 32'd7, 4'd1, 32'd5, 32'd7,
                 1'b1, 5'd3, 32'd12, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{32'h1022FFFF, 32'h10, 32'h10, 4'd12, 32'h10, 32'h10,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFC, 1'b1,
                 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[2]  = '{32'h1022FFFF, 32'h10, 32'h11, 4'd12, 32'h10, 32'h11,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'hFFFFFFFC, 1'b1,
                 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[3]  = '{32'h14220004, 32'h10, 32'h11, 4'd13, 32'h10, 32'h11,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 32'h10, 1'b1,
                 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[4]  = '{32'h2004FFFF, 32'h0, 32'h55, 4'd1, 32'h0, 32'hFFFFFFFF,
                 1'b1, 5'd4, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[5]  = '{32'h30258000, 32'hFFFFFFFF, 32'h0, 4'd2, 32'hFFFFFFFF,
                 32'h00008000, 1'b1, 5'd5, 32'h00008000, 1'b1, 1'b0,
                 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[6]  = '{32'h00051100, 32'h99, 32'd1, 4'd6, 32'd1, 32'd4,
                 1'b1, 5'd2, 32'd16, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[7]  = '{32'h00025202, 32'h0, 32'h1234, 4'd7, 32'h1234, 32'd8,
                 1'b1, 5'd10, 32'h12, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[8]  = '{32'h03E00008, 32'h400, 32'h0, 4'd0, 32'h400, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b1, 32'h400, 1'b0, 1'b0};
    vecs[9]  = '{32'hFC000000, 32'd3, 32'd4, 4'd0, 32'h0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[10] = '{32'h0022183F, 32'd3, 32'd4, 4'd0, 32'h0, 32'h0,
                 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                 1'b0, 32'h0, 1'b1, 1'b0};
    vecs[11] = '{32'h00220020, 32'd1, 32'd2, 4'd1, 32'd1, 32'd2,
                 1'b0, 5'd0, 32'd3, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[12] = '{32'h00223022, 32'd10, 32'd3, 4'd9, 32'd10, 32'd3,
                 1'b1, 5'd6, 32'd7, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[13] = '{32'h0022382A, 32'hFFFFFFFF, 32'd1, 4'd5, 32'hFFFFFFFF,
                 32'd1, 1'b1, 5'd7, 32'd1, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[14] = '{32'h2C280001, 32'h0, 32'h0, 4'd10, 32'h0, 32'd1,
                 1'b1, 5'd8, 32'd1, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[15] = '{32'h3429F0F0, 32'h0F000000, 32'h0, 4'd4, 32'h0F000000,
                 32'h0000F0F0, 1'b1, 5'd9, 32'h0F00F0F0, 1'b1, 1'b0,
                 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[16] = '{32'h00225827, 32'hF0, 32'h0F, 4'd3, 32'hF0, 32'h0F,
                 1'b1, 5'd11, 32'hFFFFFF00, 1'b1, 1'b0, 32'h0, 1'b0,
                 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[17] = '{32'h00221821, 32'h7FFFFFFF, 32'd1, 4'd11, 32'h7FFFFFFF,
                 32'd1, 1'b1, 5'd3, 32'h80000000, 1'b1, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, 1'b0};
    vecs[18] = '{32'h00221820, 32'h7FFFFFFF, 32'd1, 4'd1, 32'h7FFFFFFF,
                 32'd1, !OVF, 5'd3, 32'h80000000, 1'b1, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, OVF};
    vecs[19] = '{32'h00223022, 32'h80000000, 32'd1, 4'd9, 32'h80000000,
                 32'd1, !OVF, 5'd6, 32'h7FFFFFFF, 1'b1, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h0, 1'b0, OVF};

    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'h0;
    rs_data     = 32'h0;
    rt_data     = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", 32'(instr_ready), 32'd1);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.aluop", 32'(ALUOp), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.boff", branch_offset, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Reset while the ALU is executing: everything clears, no commit follows
    @(negedge clk);
    instr       = 32'h00221820;
    rs_data     = 32'd5;
    rt_data     = 32'd7;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("rexec.aluop_pre", 32'(ALUOp), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rexec.aluop", 32'(ALUOp), 32'd0);
    chk("rexec.c1", content1, 32'd0);
    chk("rexec.c2", content2, 32'd0);
    chk("rexec.ready", 32'(instr_ready), 32'd1);
    chk("rexec.wb_addr", 32'(wb_addr), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    chk("rexec.no_done", 32'(seen), 32'd0);

    run_vec(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
